lfsr_prng: RTL and testbench

Parametrised pseudo-random word generator for the AES-128 verification platform. It produces key, plaintext and mask stimulus words. It is a Fibonacci LFSR of configurable width and polynomial, advancing a configurable number of bits per output word. It adds runtime seed loading, zero-state lock-up protection, a post-seed warm-up phase and a valid/ready output handshake. It sits between the stimulus sequencer and the DUT input drivers; one instance per random stream.

---
 rtl/lfsr_prng.sv | 129 ++++++++++++
 tb/tb_lfsr_prng.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR pseudo-random word generator with seed loading, zero-seed
// guard, post-seed warm-up and a valid/ready output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         global advance enable (0 freezes state, FSM and counters)
//   seed_load  load seed_in this cycle (highest priority, works with en=0)
//   seed_in    seed value; zero is replaced by SEED
//   rnd_ready  consumer accepts rnd
//   rnd        current LFSR state (output word)
//   rnd_valid  rnd is valid and unconsumed (RUN & en)
//   seed_zero  one-cycle pulse after a zero seed was replaced by SEED
//   word_cnt   accepted words since last reset / seed load
module lfsr_prng #(
    parameter int unsigned      WIDTH  = 128,
    parameter logic [WIDTH-1:0] TAPS   = 128'hA000_0028_0000_0000_0000_0000_0000_0000,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
    parameter int unsigned      STEPS  = 1,
    parameter int unsigned      WARMUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             rnd_ready,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    output logic             seed_zero,
    output logic [31:0]      word_cnt
);

    localparam int unsigned WCNT_W = 8;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // With no warm-up the generator is live straight out of reset / seed load.
    localparam fsm_t START_STATE = (WARMUP == 0) ? RUN : WARM;

    fsm_t               fsm_q, fsm_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [WCNT_W-1:0]  warm_q, warm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seed_zero_q, seed_zero_d;
    logic [WIDTH-1:0]   adv_raw;
    logic [WIDTH-1:0]   adv;

    // One Fibonacci shift: parity of tapped bits enters at the LSB.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    // STEPS single shifts composed into one advance.
    always_comb begin
        adv_raw = lfsr_q;
        for (int unsigned i = 0; i < STEPS; i++) begin
            adv_raw = lfsr_step(adv_raw);
        end
    end

    // Lock-up guard: a degenerate tap mask can never park the generator at zero.
    assign adv = (adv_raw == '0) ? SEED : adv_raw;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= START_STATE;
            lfsr_q      <= SEED;
            warm_q      <= WCNT_W'(WARMUP);
            cnt_q       <= '0;
            seed_zero_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            lfsr_q      <= lfsr_d;
            warm_q      <= warm_d;
            cnt_q       <= cnt_d;
            seed_zero_q <= seed_zero_d;
        end
    end

    // Next-state: seed load beats everything, then warm-up advances, then fires.
    always_comb begin
        fsm_d       = fsm_q;
        lfsr_d      = lfsr_q;
        warm_d      = warm_q;
        cnt_d       = cnt_q;
        seed_zero_d = 1'b0;

        if (seed_load) begin
            if (seed_in == '0) begin
                lfsr_d      = SEED;
                seed_zero_d = 1'b1;
            end else begin
                lfsr_d = seed_in;
            end
            cnt_d  = '0;
            warm_d = WCNT_W'(WARMUP);
            fsm_d  = START_STATE;
        end else if (en) begin
            unique case (fsm_q)
                WARM: begin
                    lfsr_d = adv;
                    warm_d = (warm_q == '0) ? '0 : warm_q - WCNT_W'(1);
                    if (warm_q <= WCNT_W'(1)) begin
                        fsm_d = RUN;
                    end
                end
                RUN: begin
                    if (rnd_ready) begin
                        lfsr_d = adv;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                default: fsm_d = START_STATE;
            endcase
        end
    end

    assign rnd       = lfsr_q;
    assign rnd_valid = (fsm_q == RUN) & en;
    assign seed_zero = seed_zero_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: four instances (8-bit WARMUP=0,
// 8-bit WARMUP=3, 8-bit STEPS=8, default 128-bit) share one stimulus and are
// checked every cycle against a sequence model plus hand-computed literals.
module tb_lfsr_prng;

    localparam int unsigned       PW[4]     = '{8, 8, 8, 128};
    localparam int unsigned       PSTEPS[4] = '{1, 1, 8, 1};
    localparam int unsigned       PWARM[4]  = '{0, 3, 0, 4};
    localparam logic [127:0]      PT[4]     = '{128'hB8, 128'hB8, 128'hB8,
                                                128'hA000_0028_0000_0000_0000_0000_0000_0000};
    localparam logic [127:0]      PSEED[4]  = '{128'h1, 128'h1, 128'h1, 128'h1};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic         seed_load = 1'b0;
    logic         rnd_ready = 1'b1;
    logic [7:0]   seed_in8 = 8'h0;
    logic [127:0] seed_in128 = '0;

    logic [7:0]   d0_rnd, d1_rnd, d2_rnd;
    logic [127:0] d3_rnd;
    logic         d0_val, d1_val, d2_val, d3_val;
    logic         d0_sz, d1_sz, d2_sz, d3_sz;
    logic [31:0]  d0_cnt, d1_cnt, d2_cnt, d3_cnt;

    logic [127:0] a_rnd[4];
    logic         a_val[4];
    logic         a_sz[4];
    logic [31:0]  a_cnt[4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1), .WARMUP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in8),
        .rnd_ready(rnd_ready), .rnd(d0_rnd), .rnd_valid(d0_val), .seed_zero(d0_sz),
        .word_cnt(d0_cnt));

    lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1), .WARMUP(3)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in8),
        .rnd_ready(rnd_ready), .rnd(d1_rnd), .rnd_valid(d1_val), .seed_zero(d1_sz),
        .word_cnt(d1_cnt));

    lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(8), .WARMUP(0)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in8),
        .rnd_ready(rnd_ready), .rnd(d2_rnd), .rnd_valid(d2_val), .seed_zero(d2_sz),
        .word_cnt(d2_cnt));

    lfsr_prng u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in128),
        .rnd_ready(rnd_ready), .rnd(d3_rnd), .rnd_valid(d3_val), .seed_zero(d3_sz),
        .word_cnt(d3_cnt));

    assign a_rnd[0] = 128'(d0_rnd);
    assign a_rnd[1] = 128'(d1_rnd);
    assign a_rnd[2] = 128'(d2_rnd);
    assign a_rnd[3] = d3_rnd;
    assign a_val[0] = d0_val;
    assign a_val[1] = d1_val;
    assign a_val[2] = d2_val;
    assign a_val[3] = d3_val;
    assign a_sz[0]  = d0_sz;
    assign a_sz[1]  = d1_sz;
    assign a_sz[2]  = d2_sz;
    assign a_sz[3]  = d3_sz;
    assign a_cnt[0] = d0_cnt;
    assign a_cnt[1] = d1_cnt;
    assign a_cnt[2] = d2_cnt;
    assign a_cnt[3] = d3_cnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- sequence model ----------------
    // Each stream is "seed, then the polynomial sequence"; the model tracks
    // the current element, how many warm-up advances were spent and how many
    // words the consumer took.
    logic [127:0] m_state[4];
    int           m_adv[4];
    logic [31:0]  m_words[4];
    logic         m_sz[4];

    function automatic logic [127:0] m_step(input logic [127:0] s, input int k);
        logic [127:0] ones;
        logic [127:0] mask;
        logic         fb;
        ones = '1;
        mask = ones >> (128 - PW[k]);
        fb   = ^(s & PT[k]);
        return ((s << 1) | 128'(fb)) & mask;
    endfunction

    function automatic logic [127:0] m_advance(input logic [127:0] s, input int k);
        logic [127:0] r;
        r = s;
        for (int i = 0; i < int'(PSTEPS[k]); i++) r = m_step(r, k);
        return r;
    endfunction

    function automatic logic [127:0] seed_of(input int k);
        return (k == 3) ? seed_in128 : 128'(seed_in8);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_state[k] <= PSEED[k];
                m_adv[k]   <= 0;
                m_words[k] <= '0;
                m_sz[k]    <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (seed_load) begin
                    m_sz[k]    <= (seed_of(k) == '0);
                    m_state[k] <= (seed_of(k) == '0) ? PSEED[k] : seed_of(k);
                    m_adv[k]   <= 0;
                    m_words[k] <= '0;
                end else begin
                    m_sz[k] <= 1'b0;
                    if (en) begin
                        if (m_adv[k] < int'(PWARM[k])) begin
                            m_state[k] <= m_advance(m_state[k], k);
                            m_adv[k]   <= m_adv[k] + 1;
                        end else if (rnd_ready) begin
                            m_state[k] <= m_advance(m_state[k], k);
                            m_words[k] <= m_words[k] + 32'd1;
                        end
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, all instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            check($sformatf("m_rnd%0d", k), a_rnd[k], m_state[k]);
            check($sformatf("m_valid%0d", k), 128'(a_val[k]),
                  128'(en && (m_adv[k] >= int'(PWARM[k]))));
            check($sformatf("m_seed_zero%0d", k), 128'(a_sz[k]), 128'(m_sz[k]));
            check($sformatf("m_cnt%0d", k), 128'(a_cnt[k]), 128'(m_words[k]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    logic [15:0] rdy_pat;

    initial begin
        rdy_pat = 16'b1011_0010_1110_0101;

        // Reset values
        cyc();
        check("rst_rnd0", 128'(d0_rnd), 128'h01);
        check("rst_val0", 128'(d0_val), 128'h1);
        check("rst_cnt0", 128'(d0_cnt), 128'h0);
        check("rst_sz0", 128'(d0_sz), 128'h0);
        check("rst_val1", 128'(d1_val), 128'h0);
        check("rst_rnd3", d3_rnd, 128'h1);
        rst_n = 1'b1;

        // Post-reset sequence 01,02,04,08,11,23; warm-up and STEPS=8 pins
        cyc();
        check("seq1_rnd0", 128'(d0_rnd), 128'h02);
        check("stp8_rnd2", 128'(d2_rnd), 128'h1C);
        check("warm1_val1", 128'(d1_val), 128'h0);
        cyc();
        check("seq2_rnd0", 128'(d0_rnd), 128'h04);
        check("warm2_val1", 128'(d1_val), 128'h0);
        cyc();
        check("seq3_rnd0", 128'(d0_rnd), 128'h08);
        check("warm_rnd1", 128'(d1_rnd), 128'h08);
        check("warm_val1", 128'(d1_val), 128'h1);
        check("warm_cnt1", 128'(d1_cnt), 128'h0);
        cyc();
        check("seq4_rnd0", 128'(d0_rnd), 128'h11);
        check("warm_rnd3", d3_rnd, 128'h10);
        check("warm_val3", 128'(d3_val), 128'h1);
        cyc();
        check("seq5_rnd0", 128'(d0_rnd), 128'h23);

        // Full period: back to 01 after exactly 255 fires
        repeat (250) cyc();
        check("period_rnd0", 128'(d0_rnd), 128'h01);
        check("period_cnt0", 128'(d0_cnt), 128'd255);
        check("period_rnd2", 128'(d2_rnd), 128'h01);
        check("period_cnt2", 128'(d2_cnt), 128'd255);

        // Backpressure: 10 cycles of ready=0 hold rnd and word_cnt
        rnd_ready = 1'b0;
        repeat (10) cyc();
        check("bp_rnd0", 128'(d0_rnd), 128'h01);
        check("bp_cnt0", 128'(d0_cnt), 128'd255);
        check("bp_val0", 128'(d0_val), 128'h1);
        rnd_ready = 1'b1;
        cyc();
        check("bp_next_rnd0", 128'(d0_rnd), 128'h02);
        check("bp_next_cnt0", 128'(d0_cnt), 128'd256);

        // Nonzero seed load restarts warm-up
        seed_in8   = 8'h01;
        seed_in128 = 128'h1;
        seed_load  = 1'b1;
        cyc();
        check("ld_rnd0", 128'(d0_rnd), 128'h01);
        check("ld_cnt0", 128'(d0_cnt), 128'h0);
        check("ld_sz0", 128'(d0_sz), 128'h0);
        check("ld_val1", 128'(d1_val), 128'h0);
        seed_load = 1'b0;
        repeat (3) cyc();
        check("ld_warm_rnd1", 128'(d1_rnd), 128'h08);
        check("ld_warm_val1", 128'(d1_val), 128'h1);
        check("ld_warm_cnt1", 128'(d1_cnt), 128'h0);

        // Zero seed replaced by SEED, seed_zero pulses once
        seed_in8   = 8'h00;
        seed_in128 = '0;
        seed_load  = 1'b1;
        cyc();
        seed_load = 1'b0;
        check("zs_sz0", 128'(d0_sz), 128'h1);
        check("zs_rnd0", 128'(d0_rnd), 128'h01);
        check("zs_cnt0", 128'(d0_cnt), 128'h0);
        check("zs_sz3", 128'(d3_sz), 128'h1);
        check("zs_rnd3", d3_rnd, 128'h1);
        cyc();
        check("zs_pulse0", 128'(d0_sz), 128'h0);
        check("zs_seq_rnd0", 128'(d0_rnd), 128'h02);
        cyc();
        check("zs_seq2_rnd0", 128'(d0_rnd), 128'h04);

        // en=0 freezes everything
        en = 1'b0;
        #1;
        check("en0_val0", 128'(d0_val), 128'h0);
        repeat (5) cyc();
        check("en0_rnd0", 128'(d0_rnd), 128'h04);
        check("en0_cnt0", 128'(d0_cnt), 128'd2);
        en = 1'b1;
        cyc();
        check("en1_rnd0", 128'(d0_rnd), 128'h08);
        check("en1_cnt0", 128'(d0_cnt), 128'd3);

        // Seed load wins over ready, and works with en=0
        seed_in128 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        seed_in8   = 8'h5A;
        seed_load  = 1'b1;
        en         = 1'b0;
        cyc();
        check("sw_rnd3", d3_rnd, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
        check("sw_cnt3", 128'(d3_cnt), 128'h0);
        check("sw_rnd0", 128'(d0_rnd), 128'h5A);
        seed_load = 1'b0;
        en        = 1'b1;
        seed_in8  = 8'h01;
        seed_load = 1'b1;
        cyc();
        check("sw2_cnt0", 128'(d0_cnt), 128'h0);
        seed_load = 1'b0;

        // Irregular ready pattern, model-checked
        for (int i = 0; i < 16; i++) begin
            rnd_ready = rdy_pat[i];
            cyc();
        end
        rnd_ready = 1'b1;
        repeat (6) cyc();

        // Asynchronous reset mid-RUN
        rst_n = 1'b0;
        #1;
        check("arst_rnd3", d3_rnd, 128'h1);
        check("arst_cnt3", 128'(d3_cnt), 128'h0);
        check("arst_val3", 128'(d3_val), 128'h0);
        check("arst_rnd0", 128'(d0_rnd), 128'h01);
        check("arst_cnt0", 128'(d0_cnt), 128'h0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        check("arst_seq_rnd0", 128'(d0_rnd), 128'h02);
        repeat (6) cyc();

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
